// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types, stock video modes and helpers for the
// VGA timing generator.
//   vga_timing_t : one axis of a timing set (active / front porch / sync / back porch)
//   vga_mode_t   : a full mode, horizontal + vertical axes plus sync polarities
//   VGA_640x480  : 25.175 MHz industry mode, negative syncs
//   VGA_800x600  : 40 MHz mode, positive syncs
//   vga_total()  : total length of one axis in pixels or lines
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
        logic        hsync_pol;
        logic        vsync_pol;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480 = '{
        h:         '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48},
        v:         '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33},
        hsync_pol: 1'b0,
        vsync_pol: 1'b0
    };

    localparam vga_mode_t VGA_800x600 = '{
        h:         '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88},
        v:         '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23},
        hsync_pol: 1'b1,
        vsync_pol: 1'b1
    };

    function automatic int unsigned vga_total(vga_timing_t t);
        return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundle between the timing generator and the renderer.
//   master (timing generator): drives x, y, active, sync, colour outputs,
//                              pix_en and the line/frame strobes; reads the
//                              colour returned by the renderer.
//   slave  (renderer/monitor): reads the coordinates and outputs, drives
//                              red/green/blue for the current (x,y).
// There is no valid/ready handshake here: the renderer must present the colour
// for the current (x,y) combinationally; it is sampled on every pix_en cycle.
interface vga_timing_gen_if #(
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int COLOR_W = 4
);
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic               active;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] vga_red;
    logic [COLOR_W-1:0] vga_green;
    logic [COLOR_W-1:0] vga_blue;
    logic               pix_en;
    logic               line_start;
    logic               frame_start;

    modport master (
        output x, y, active, hsync, vsync,
        output vga_red, vga_green, vga_blue,
        output pix_en, line_start, frame_start,
        input  red, green, blue
    );

    modport slave (
        input  x, y, active, hsync, vsync,
        input  vga_red, vga_green, vga_blue,
        input  pix_en, line_start, frame_start,
        output red, green, blue
    );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one axis (horizontal or vertical) of the raster.
//   clk, reset : system clock, synchronous active-high reset
//   adv        : advance the counter by one this cycle
//   cnt        : current position, 0..TOTAL-1
//   active     : cnt lies in the visible part of the axis
//   in_sync    : cnt lies in [SYNC_START, SYNC_START+SYNC_LEN)
//   wrap       : advancing from the last position this cycle (counter returns to 0)
module vga_axis_counter #(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96,
    parameter int          W          = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         in_sync,
    output logic         wrap
);

    logic [31:0] cnt32;
    logic        last;

    // Compare at 32 bits: SYNC_START+SYNC_LEN may equal TOTAL, which need not
    // fit in W bits when TOTAL is a power of two.
    assign cnt32   = 32'(cnt);
    assign last    = (cnt32 == TOTAL - 1);
    assign active  = (cnt32 < ACTIVE);
    assign in_sync = (cnt32 >= SYNC_START) && (cnt32 < SYNC_START + SYNC_LEN);
    assign wrap    = adv && last;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (adv) begin
            if (last) cnt <= '0;
            else      cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing and pixel output stage.
//   clk, reset : single system clock, synchronous active-high reset
//   vga        : vga_timing_gen_if master port
//                x, y          raster counters (0..H_TOTAL-1, 0..V_TOTAL-1)
//                active        (x,y) visible, combinational from the counters
//                red/green/blue colour from the renderer for the current (x,y)
//                hsync, vsync  registered syncs with programmable polarity
//                vga_*         registered colour, forced to 0 outside the visible area
//                pix_en        one clk in CLK_DIV, the pixel-advance strobe
//                line_start    last clk of the last pixel of a line
//                frame_start   last clk of the last pixel of a frame
// Colour and sync for a coordinate are registered on the edge that ends its
// pix_en cycle, i.e. the same edge on which x advances.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 32'(VGA_640x480.h.active),
    parameter int unsigned H_FP      = 32'(VGA_640x480.h.fp),
    parameter int unsigned H_SYNC    = 32'(VGA_640x480.h.sync),
    parameter int unsigned H_BP      = 32'(VGA_640x480.h.bp),
    parameter int unsigned V_ACTIVE  = 32'(VGA_640x480.v.active),
    parameter int unsigned V_FP      = 32'(VGA_640x480.v.fp),
    parameter int unsigned V_SYNC    = 32'(VGA_640x480.v.sync),
    parameter int unsigned V_BP      = 32'(VGA_640x480.v.bp),
    parameter bit          HSYNC_POL = VGA_640x480.hsync_pol,
    parameter bit          VSYNC_POL = VGA_640x480.vsync_pol,
    parameter int unsigned CLK_DIV   = 1,
    parameter int          COLOR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam vga_timing_t H_TIMING = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                         sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_timing_t V_TIMING = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                         sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int unsigned H_TOTAL  = vga_total(H_TIMING);
    localparam int unsigned V_TOTAL  = vga_total(V_TIMING);
    localparam int          XW       = $clog2(H_TOTAL);
    localparam int          YW       = $clog2(V_TOTAL);

    logic          pix_en;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_active, v_active;
    logic          h_in_sync, v_in_sync;
    logic          h_wrap, v_wrap;
    logic          active;

    logic               hsync_q, vsync_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;

    // Pixel-clock divider. With CLK_DIV=1 every clk is a pixel.
    if (CLK_DIV > 1) begin : g_div
        localparam int DW = $clog2(CLK_DIV);
        logic [DW-1:0] div;

        assign pix_en = (32'(div) == CLK_DIV - 1);

        always_ff @(posedge clk) begin
            if (reset)       div <= '0;
            else if (pix_en) div <= '0;
            else             div <= div + 1'b1;
        end
    end else begin : g_no_div
        assign pix_en = 1'b1;
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .W          (XW)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .adv     (pix_en),
        .cnt     (h_cnt),
        .active  (h_active),
        .in_sync (h_in_sync),
        .wrap    (h_wrap)
    );

    // The vertical axis steps once per line, on the horizontal wrap, so its
    // wrap is exactly the end of the frame.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .W          (YW)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .adv     (h_wrap),
        .cnt     (v_cnt),
        .active  (v_active),
        .in_sync (v_in_sync),
        .wrap    (v_wrap)
    );

    assign active = h_active && v_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (pix_en) begin
            hsync_q <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync_q <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
            red_q   <= active ? vga.red   : '0;
            green_q <= active ? vga.green : '0;
            blue_q  <= active ? vga.blue  : '0;
        end
    end

    assign vga.x           = h_cnt;
    assign vga.y           = v_cnt;
    assign vga.active      = active;
    assign vga.pix_en      = pix_en;
    // Strobes are combinational; reset masks them so a reset landing on the
    // last pixel cannot emit a stray line/frame start.
    assign vga.line_start  = h_wrap && !reset;
    assign vga.frame_start = v_wrap && !reset;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.vga_red     = red_q;
    assign vga.vga_green   = green_q;
    assign vga.vga_blue    = blue_q;

endmodule
